// File: rtl/fir_coef_loader.sv
// Streaming coefficient loader: writes NCOEFS words to tap storage,
// then validates the set against a trailing modular checksum word.
module fir_coef_loader #(
  parameter int WIDTH  = 8,
  parameter int NCOEFS = 300,
  parameter int AW     = $clog2(NCOEFS)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             coef_wr_en,
  output logic [AW-1:0]    coef_wr_addr,
  output logic [WIDTH-1:0] coef_wr_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             coef_valid
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NCOEFS - 1);

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] sum;
  logic             hs;

  assign hs = s_valid && s_ready;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state        <= IDLE;
      cnt          <= '0;
      sum          <= '0;
      s_ready      <= 1'b0;
      coef_wr_en   <= 1'b0;
      coef_wr_addr <= '0;
      coef_wr_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      coef_valid   <= 1'b0;
    end else begin
      coef_wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LOAD;
            cnt        <= '0;
            sum        <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            coef_valid <= 1'b0;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (hs) begin
            coef_wr_en   <= 1'b1;
            coef_wr_addr <= cnt;
            coef_wr_data <= s_data;
            sum          <= sum + s_data;
            if (cnt == LAST) state <= CHECK;
            else cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (abort) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (hs) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            // sum already includes the final coefficient here
            if (s_data == sum) begin
              state      <= DONE;
              done       <= 1'b1;
              coef_valid <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
